// File: rtl/decred_io_pkg.sv
// decred_io_pkg: shared types and constants for the Decred pad front end.
//   state_e      - front-end state (hold-off / running)
//   DefOutMask   - default set of drivable pads (12..20)
//   DefLedPads   - default LED pad indices, 6 bits per channel, channel 0 in the LSBs
//   is_led_pad() - true when a pad index appears in a packed LED pad list
package decred_io_pkg;

   typedef enum logic {
      StHold = 1'b0,
      StRun  = 1'b1
   } state_e;

   localparam int unsigned DefNumPads = 38;
   localparam logic [37:0] DefOutMask = 38'h0_001F_F000;
   localparam logic [11:0] DefLedPads = {6'd19, 6'd17};
   localparam int unsigned MaxLed     = 16;
   localparam int unsigned PadIdxW    = 6;

   function automatic logic is_led_pad(input int unsigned                  idx,
                                       input logic [MaxLed*PadIdxW-1:0] pads,
                                       input int unsigned                  num_led);
      logic hit;
      hit = 1'b0;
      for (int unsigned k = 0; k < MaxLed; k++) begin
         if (k < num_led && 32'(pads[k*PadIdxW +: PadIdxW]) == idx) begin
            hit = 1'b1;
         end
      end
      return hit;
   endfunction

endpackage

// File: rtl/decred_io_filter.sv
// decred_io_filter: one pad input through a 2-FF synchroniser, optionally followed by a
// stability filter that only passes a new level after FILT_CYCLES consecutive cycles.
// Build option: DECRED_IO_GLITCH_FILTER_EN enables the filter; otherwise dout is the
// plain synchroniser output.
//   clk   - clock
//   rst_n - asynchronous active-low reset (already release-synchronised)
//   din   - raw pad input
//   dout  - synchronised (and optionally filtered) input
module decred_io_filter #(
   parameter int unsigned FILT_CYCLES = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], din};
      end
   end

`ifdef DECRED_IO_GLITCH_FILTER_EN
   logic [3:0] cnt_q, cnt_d;
   logic       filt_q, filt_d;

   // Counter tracks how long the synchronised level has disagreed with the output;
   // any agreement (bounce) clears it.
   always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (sync_q[1] != filt_q) begin
         if (cnt_q == 4'(FILT_CYCLES - 1)) begin
            filt_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

   assign dout = filt_q;
`else
   assign dout = sync_q[1];
`endif

endmodule

// File: rtl/decred_io_frontend.sv
// decred_io_frontend: pad front end between the user IO ring and the miner core.
// Synchronises (optionally filters) every pad input, holds all pads high-Z for OEB_HOLD
// cycles after reset release, then drives masked core outputs. LED pads OR in a
// pulse stretcher so single-cycle events stay visible for 2^LED_STRETCH_W cycles.
// Build option: DECRED_IO_GLITCH_FILTER_EN enables per-pad input glitch filtering.
//   wb_clk_i  - clock
//   wb_rst_ni - asynchronous active-low reset, release synchronised internally
//   io_in     - raw pad inputs          io_out   - pad output data
//   io_oeb    - pad output enable (low) core_in  - synchronised inputs to the core
//   core_out  - core output data        core_oe  - core output enable (high)
//   led_evt   - LED events              ready    - high once outputs are released
module decred_io_frontend
   import decred_io_pkg::*;
#(
   parameter int unsigned             NUM_PADS      = DefNumPads,
   parameter logic [NUM_PADS-1:0]     OUT_MASK      = DefOutMask,
   parameter int unsigned             OEB_HOLD      = 16,
   parameter int unsigned             FILT_CYCLES   = 3,
   parameter int unsigned             NUM_LED       = 2,
   parameter logic [NUM_LED*6-1:0]    LED_PADS      = DefLedPads,
   parameter int unsigned             LED_STRETCH_W = 20
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_ni,
   input  logic [NUM_PADS-1:0] io_in,
   output logic [NUM_PADS-1:0] io_out,
   output logic [NUM_PADS-1:0] io_oeb,
   output logic [NUM_PADS-1:0] core_in,
   input  logic [NUM_PADS-1:0] core_out,
   input  logic [NUM_PADS-1:0] core_oe,
   input  logic [NUM_LED-1:0]  led_evt,
   output logic                ready
);

   localparam logic [7:0]                 HoldLast   = 8'(OEB_HOLD - 1);
   localparam logic [MaxLed*PadIdxW-1:0] LedPadsExt = (MaxLed*PadIdxW)'(LED_PADS);

   // Reset: asserted asynchronously, released through two flops.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n = rst_sync_q[1];

   // Input path.
   for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad_in
      decred_io_filter #(
         .FILT_CYCLES(FILT_CYCLES)
      ) u_filter (
         .clk  (wb_clk_i),
         .rst_n(rst_n),
         .din  (io_in[i]),
         .dout (core_in[i])
      );
   end

   // LED stretchers.
   logic [NUM_LED-1:0] led_active;

   for (genvar k = 0; k < NUM_LED; k++) begin : g_led
      logic [LED_STRETCH_W-1:0] cnt_q, cnt_d;
      logic                     active_q, active_d;

      // Active drops one cycle after the counter empties so the stretch spans
      // exactly 2^LED_STRETCH_W cycles.
      always_comb begin
         cnt_d    = cnt_q;
         active_d = active_q;
         if (led_evt[k]) begin
            cnt_d    = '1;
            active_d = 1'b1;
         end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
         end else begin
            active_d = 1'b0;
         end
      end

      always_ff @(posedge wb_clk_i or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
         end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
         end
      end

      assign led_active[k] = active_q;
   end

   logic [NUM_PADS-1:0] led_mask;
   logic [NUM_PADS-1:0] led_pad_on;

   for (genvar i = 0; i < NUM_PADS; i++) begin : g_led_mask
      assign led_mask[i] = is_led_pad(i, LedPadsExt, NUM_LED);
   end

   always_comb begin
      led_pad_on = '0;
      for (int i = 0; i < int'(NUM_PADS); i++) begin
         for (int k = 0; k < int'(NUM_LED); k++) begin
            if (int'(LED_PADS[k*6 +: 6]) == i) begin
               led_pad_on[i] = led_pad_on[i] | led_active[k];
            end
         end
      end
   end

   // Hold-off FSM: state register.
   state_e     state_q, state_d;
   logic [7:0] hold_q, hold_d;

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StHold;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   // Hold-off FSM: next state. RUN is left only through reset.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         StHold: begin
            if (hold_q == HoldLast) begin
               state_d = StRun;
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         StRun:   state_d = StRun;
         default: state_d = StHold;
      endcase
   end

   // Hold-off FSM: outputs, combinational from core signals while running.
   always_comb begin
      io_out = '0;
      io_oeb = '1;
      ready  = 1'b0;
      if (state_q == StRun) begin
         ready  = 1'b1;
         io_out = (OUT_MASK & core_out) | (led_mask & led_pad_on);
         io_oeb = ~(OUT_MASK & core_oe) & ~led_mask;
      end
   end

endmodule

// File: tb/tb_decred_io_frontend.sv
module tb_decred_io_frontend;

   localparam int unsigned N = 38;
`ifdef DECRED_IO_GLITCH_FILTER_EN
   localparam int Lat    = 5;
   localparam int Glitch1 = 0;
   localparam int Glitch2 = 0;
`else
   localparam int Lat    = 2;
   localparam int Glitch1 = 1;
   localparam int Glitch2 = 2;
`endif

   localparam logic [N-1:0] AllOnes = 38'h3F_FFFF_FFFF;
   localparam logic [N-1:0] RunOeb  = 38'h3F_FFE0_0FFF;
   localparam logic [N-1:0] RunOut  = 38'h00_001F_F000;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] io_in, io_out, io_oeb, core_in, core_out, core_oe;
   logic [1:0]   led_evt;
   logic         ready;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   decred_io_frontend #(
      .LED_STRETCH_W(4)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_ni(rst_n),
      .io_in    (io_in),
      .io_out   (io_out),
      .io_oeb   (io_oeb),
      .core_in  (core_in),
      .core_out (core_out),
      .core_oe  (core_oe),
      .led_evt  (led_evt),
      .ready    (ready)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Releases reset at a negedge and checks the hold-off window edge by edge.
   task automatic release_and_check_hold();
      rst_n = 1'b1;
      for (int j = 1; j <= 20; j++) begin
         tick();
         check($sformatf("ready_e%0d", j), 64'(ready), 64'(j >= 18));
         check($sformatf("oeb_e%0d", j), 64'(io_oeb), 64'(j >= 18 ? RunOeb : AllOnes));
      end
   endtask

   int highs;

   initial begin
      rst_n    = 1'b0;
      io_in    = '0;
      core_out = '1;
      core_oe  = '1;
      led_evt  = '0;
      repeat (3) tick();

      check("rst_oeb", 64'(io_oeb), 64'(AllOnes));
      check("rst_out", 64'(io_out), 64'h0);
      check("rst_core_in", 64'(core_in), 64'h0);
      check("rst_ready", 64'(ready), 64'h0);

      release_and_check_hold();
      check("run_out", 64'(io_out), 64'(RunOut));
      check("pad30_oeb", 64'(io_oeb[30]), 64'h1);
      check("pad30_out", 64'(io_out[30]), 64'h0);

      // Partial enables: pads 12,14,16,18 enabled plus LED pads 17,19 forced on.
      core_oe  = 38'h00_0005_5000;
      #1;
      check("part_oeb", 64'(io_oeb), 64'h3F_FFF0_AFFF);
      check("part_out", 64'(io_out), 64'(RunOut));
      core_out = '0;
      core_oe  = '0;
      #1;
      check("idle_oeb", 64'(io_oeb), 64'h3F_FFF5_FFFF);
      check("idle_out", 64'(io_out), 64'h0);
      tick();

      // Input latency on pad 5.
      io_in[5] = 1'b1;
      for (int j = 1; j <= Lat + 1; j++) begin
         tick();
         check($sformatf("in5_rise_e%0d", j), 64'(core_in[5]), 64'(j >= Lat));
      end
      io_in[5] = 1'b0;
      repeat (Lat + 3) tick();
      check("in5_fall", 64'(core_in[5]), 64'h0);

      // One-cycle glitch, then a two-cycle glitch.
      highs = 0;
      io_in[5] = 1'b1;
      tick();
      io_in[5] = 1'b0;
      if (core_in[5]) highs++;
      for (int j = 0; j < 9; j++) begin
         tick();
         if (core_in[5]) highs++;
      end
      check("glitch1_highs", 64'(highs), 64'(Glitch1));
      highs = 0;
      io_in[5] = 1'b1;
      tick();
      if (core_in[5]) highs++;
      tick();
      io_in[5] = 1'b0;
      if (core_in[5]) highs++;
      for (int j = 0; j < 9; j++) begin
         tick();
         if (core_in[5]) highs++;
      end
      check("glitch2_highs", 64'(highs), 64'(Glitch2));
      check("glitch_core_in", 64'(core_in), 64'h0);

      // Single LED event on channel 1 (pad 19): high for 16 cycles.
      led_evt[1] = 1'b1;
      tick();
      led_evt[1] = 1'b0;
      check("led1_oeb", 64'(io_oeb[19]), 64'h0);
      for (int j = 1; j <= 20; j++) begin
         check($sformatf("led1_c%0d", j), 64'(io_out[19]), 64'(j <= 16));
         check($sformatf("led0_c%0d", j), 64'(io_out[17]), 64'h0);
         tick();
      end

      // Retrigger at cycle 10: high through cycle 26.
      led_evt[1] = 1'b1;
      tick();
      led_evt[1] = 1'b0;
      for (int j = 1; j <= 30; j++) begin
         if (j == 10) led_evt[1] = 1'b1;
         if (j == 11) led_evt[1] = 1'b0;
         check($sformatf("led_rt_c%0d", j), 64'(io_out[19]), 64'(j <= 26));
         tick();
      end

      // Level-held event keeps the LED on.
      led_evt[0] = 1'b1;
      tick();
      for (int j = 0; j < 24; j++) tick();
      check("led_level", 64'(io_out[17]), 64'h1);
      led_evt[0] = 1'b0;
      repeat (20) tick();
      check("led_level_off", 64'(io_out[17]), 64'h0);

      // Asynchronous reset mid-run with pads driven.
      core_out = '1;
      core_oe  = '1;
      #1;
      check("pre_rst_oeb", 64'(io_oeb), 64'(RunOeb));
      #1;
      rst_n = 1'b0;
      #1;
      check("async_oeb", 64'(io_oeb), 64'(AllOnes));
      check("async_out", 64'(io_out), 64'h0);
      check("async_ready", 64'(ready), 64'h0);
      @(negedge clk);
      release_and_check_hold();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
